// File: rtl/imem_pkg.sv
// Shared definitions for the block-granular instruction memory.
//   IMEM_BYTES / IMEM_ADDR_W   : byte array depth and byte address width
//   BLOCK_BYTES / BLOCK_OFF_W  : bytes per block and in-block offset width
//   BLOCK_ADDR_W / BLOCK_W     : block address width and returned block width
//   IMEM_LATENCY               : default accept-to-data latency in clock edges
//   state_e                    : read FSM states
package imem_pkg;

  localparam int IMEM_BYTES   = 1024;
  localparam int IMEM_ADDR_W  = 10;
  localparam int BLOCK_BYTES  = 16;
  localparam int BLOCK_OFF_W  = 4;
  localparam int BLOCK_ADDR_W = 6;
  localparam int BLOCK_W      = 128;
  localparam int IMEM_LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/instruction_memory_if.sv
// Bus between an instruction cache (master) and the instruction memory (slave).
//   read       : block read request
//   address    : block address, byte base = {address, 4'b0000}
//   readinst   : returned 128-bit block
//   busywait   : high while a read is in flight
//   prog_write : byte program strobe
//   prog_addr  : byte address to program
//   prog_data  : byte value to program
interface instruction_memory_if;
  import imem_pkg::*;

  logic                    read;
  logic [BLOCK_ADDR_W-1:0] address;
  logic [BLOCK_W-1:0]      readinst;
  logic                    busywait;
  logic                    prog_write;
  logic [IMEM_ADDR_W-1:0]  prog_addr;
  logic [7:0]              prog_data;

  modport master (
    output read, address, prog_write, prog_addr, prog_data,
    input  readinst, busywait
  );

  modport slave (
    input  read, address, prog_write, prog_addr, prog_data,
    output readinst, busywait
  );

endinterface

// File: rtl/imem_array.sv
// 1024 x 8 instruction storage with one byte write port and one block-wide
// combinational read port that packs 16 bytes into CPU fetch order.
//   clk   : write clock
//   we    : byte write enable
//   waddr : byte write address
//   wdata : byte write data
//   raddr : block read address
//   rdata : packed block; word k = {mem[B+4k], .., mem[B+4k+3]} at [32k+31:32k]
module imem_array
  import imem_pkg::*;
(
  input  logic                    clk,
  input  logic                    we,
  input  logic [IMEM_ADDR_W-1:0]  waddr,
  input  logic [7:0]              wdata,
  input  logic [BLOCK_ADDR_W-1:0] raddr,
  output logic [BLOCK_W-1:0]      rdata
);

  logic [7:0] mem [IMEM_BYTES];

  // NOTE: storage has no reset on purpose; contents must survive a RESET and a
  // resettable array would not map onto RAM.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Byte j of the block is word j/4, and within a word the lowest address is
  // the most significant byte.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rdata = '0;
    for (int j = 0; j < BLOCK_BYTES; j++) begin
      rdata[32*(j/4) + 31 - 8*(j%4) -: 8] = mem[{raddr, BLOCK_OFF_W'(j)}];
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory answering icache block misses with a fixed latency and a
// busywait handshake. Byte programming is accepted only while idle so the
// array never changes under an in-flight read.
//   CLK   : clock, all state changes on the rising edge
//   RESET : asynchronous active-high; clears control state, not array contents
//   bus   : instruction_memory_if slave (read/address/readinst/busywait and
//           the prog_write/prog_addr/prog_data program port)
module instruction_memory
  import imem_pkg::*;
#(
  parameter int LATENCY = IMEM_LATENCY
) (
  input  logic               CLK,
  input  logic               RESET,
  instruction_memory_if.slave bus
);

  // Counter holds LATENCY-1 down to 0, which always fits in clog2(LATENCY).
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e                  state_q,    state_d;
  logic [CNT_W-1:0]        cnt_q,      cnt_d;
  logic [BLOCK_ADDR_W-1:0] addr_q,     addr_d;
  logic                    busywait_q, busywait_d;
  logic [BLOCK_W-1:0]      readinst_q, readinst_d;

  logic                    prog_we;
  logic [BLOCK_W-1:0]      rd_block;

  imem_array u_array (
    .clk   (CLK),
    .we    (prog_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (addr_q),
    .rdata (rd_block)
  );

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      busywait_q <= 1'b0;
      readinst_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      busywait_q <= busywait_d;
      readinst_q <= readinst_d;
    end
  end

  // Next-state logic. busywait is computed here so it leaves as a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    busywait_d = busywait_q;
    readinst_d = readinst_q;
    unique case (state_q)
      IDLE: begin
        if (bus.read) begin
          state_d    = BUSY;
          addr_d     = bus.address;
          cnt_d      = CNT_W'(LATENCY - 1);
          busywait_d = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          // Data edge: the latched address, not the live one, selects the block.
          readinst_d = rd_block;
          busywait_d = 1'b0;
          state_d    = ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACK: begin
        // read is ignored here, which enforces the LATENCY+2 issue interval.
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        busywait_d = 1'b0;
      end
    endcase
  end

  // Outputs. A write on the accept edge still lands before the data edge, so
  // a same-edge program+read returns the new byte.
  always_comb begin
    prog_we      = bus.prog_write && (state_q == IDLE);
    bus.busywait = busywait_q;
    bus.readinst = readinst_q;
  end

endmodule

// File: doc/instruction_memory.md
# instruction_memory

Block-granular, read-only-at-runtime instruction store that answers instruction-cache miss requests with a fixed multi-cycle latency and a busywait handshake. It serves 16-byte blocks out of a 1024-byte array, in the same block/busywait convention as the data memory behind the data cache. A byte-wide program port loads the array before or between fetches. It replaces the behavioural instruction array in CPU benches.

## Interface
- LATENCY, 5: clock cycles from request acceptance to data delivery (≥2).
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high; clears control state, not array contents.
- read  in  1  block read request from icache.
- address  in  6  block address; byte base = {address, 4'b0000}.
- readinst  out  128  returned block.
- busywait  out  1  high while a read is in flight.
- prog_write  in  1  byte program strobe.
- prog_addr  in  10  byte address for programming.
- prog_data  in  8  byte to store.

## Operation
- Storage: 1024 × 8-bit array. Not cleared by RESET.
- Block packing: word k (k = 0..3) occupies readinst[32k+31:32k]. Word = {mem[B+4k], mem[B+4k+1], mem[B+4k+2], mem[B+4k+3]}, with B = byte base. The lowest byte address is the MSB of each word, matching CPU fetch order.
- FSM states:
  - IDLE: busywait = 0. A rising edge with read = 1 latches address, loads cnt = LATENCY−1, sets busywait = 1, and goes to BUSY.
  - BUSY: busywait = 1. Decrement cnt each edge. On the edge where cnt = 0, load readinst from the array at the latched address, clear busywait, and go to ACK.
  - ACK: busywait = 0, readinst valid. read is ignored. Next edge returns to IDLE.
- Address and read changes during BUSY/ACK are ignored. The latched address is used.
- prog_write: honoured only in IDLE. On the edge, mem[prog_addr] ← prog_data. Ignored in BUSY and ACK, so no array change is visible mid-read.
- prog_write and read on the same IDLE edge: the write is performed and the read starts. The returned block reflects the new byte.
- Reset values: state = IDLE, busywait = 0, readinst = 0, cnt = 0, latched address = 0.
- RESET mid-BUSY aborts the read, with no data delivered. After release, the block is idle and a new read starts normally.

## Timing
- Accept edge (read = 1 in IDLE) to data edge is exactly LATENCY edges. busywait is high for LATENCY full cycles.
- readinst updates only on the data edge. It holds its value until the next data edge or RESET.
- Back-to-back reads: minimum issue interval is LATENCY + 2 edges (BUSY, ACK, IDLE accept).
- busywait, readinst and state are all registered. There is no combinational path from inputs to outputs.
- prog_write has a single-edge effect, with no busywait involvement.

## Structure
- Shared package imem_pkg holds:
  - IMEM_BYTES = 1024, BLOCK_BYTES = 16, BLOCK_ADDR_W = 6, BLOCK_W = 128.
  - Default LATENCY.
  - state enum {IDLE, BUSY, ACK}.
- Sub-module imem_array: 1024 × 8 storage with one byte write port and one 16-byte-wide read port that performs the packing. The FSM and counter stay in instruction_memory.

## Test plan
- Program bytes 0–15 as 00 01 00 01, 00 05 00 05, 14 00 01 05, 12 03 00 05, then read address 0:
  - busywait is high for 5 cycles.
  - readinst = 128'h12030005_14000105_00050005_00010001.
  - busywait = 0 in ACK.
- Read address 6'h3F after programming byte 1023 = 8'hA5: readinst[103:96] = 8'hA5, since byte 1023 is the LSB of word 3.
- Change address from 0 to 1 and pulse prog_write to byte 0 = 8'hFF during BUSY: the returned block equals the original address-0 contents, and byte 0 is still 00.
- Hold read high continuously:
  - read is ignored in ACK.
  - A second busywait pulse starts exactly LATENCY + 2 edges after the first accept.
- Assert RESET 2 cycles into BUSY:
  - busywait drops asynchronously and readinst = 0.
  - A subsequent read of address 0 returns the programmed block, showing contents survive reset.
- Same-edge prog_write (byte 4 = 8'h77) and read of address 0 in IDLE: returned word 1 = 32'h77050005.
